mem_access_ctrl: RTL

Sequences data-memory accesses for the pipeline's MEM stage against a variable-latency data memory that uses a req/ack handshake. Holds the MEM-stage instruction and every upstream stage while an access is outstanding, and drives a bubble into the MEM/WB pipeline register on each held cycle. Captures read data for the WB stage. Provides a watchdog timeout, a sticky error flag and a stall-cycle counter for debug.

---
 rtl/mem_access_ctrl_if.sv | 30 +++
 rtl/mem_access_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge bus between the MEM-stage access controller and a
// variable-latency data memory.
interface mem_access_ctrl_if;
  localparam int unsigned DATA_W = 32;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: holds the pipeline during a req/ack access,
// captures load data for WB, and provides watchdog, sticky error and stall count.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memread_MEM,
  input  logic                 memwrite_MEM,
  input  logic [31:0]          aluresult_MEM,
  input  logic [31:0]          writedata_MEM,
  mem_access_ctrl_if.master    mem,
  output logic [31:0]          readdata_MEM,
  output logic                 stall,
  output logic                 flush_WB,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned WD_W      = 8;
  localparam logic [WD_W-1:0] TIMEOUT_W = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [WD_W-1:0]   r_wd;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_op;
  logic              w_active;
  logic [WD_W-1:0]   w_wd_inc;
  logic              w_timeout;
  logic [31:0]       w_cap_data;

  // Request is live in the issuing IDLE cycle and throughout WAIT_ACK; reset
  // kills it immediately even while the MEM-stage inputs are still asserted.
  assign w_op       = memread_MEM | memwrite_MEM;
  assign w_active   = !reset && (((r_state == S_IDLE) && w_op) || (r_state == S_WAIT_ACK));
  assign w_wd_inc   = r_wd + WD_W'(1);
  assign w_timeout  = (r_state == S_WAIT_ACK) && !mem.mem_ack && (w_wd_inc == TIMEOUT_W);
  assign w_cap_data = memwrite_MEM ? 32'h0000_0000 : mem.mem_rdata;

  assign mem.mem_req   = w_active;
  assign mem.mem_we    = w_active & memwrite_MEM;
  assign mem.mem_addr  = w_active ? aluresult_MEM : 32'h0000_0000;
  assign mem.mem_wdata = w_active ? writedata_MEM : 32'h0000_0000;

  assign stall        = w_active;
  assign flush_WB     = w_active;
  assign readdata_MEM = r_rdata;
  assign mem_err      = r_err;
  assign stall_cnt    = r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wd        <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_active && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_op) begin
            if (mem.mem_ack) begin
              r_rdata <= w_cap_data;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT_ACK;
            end
          end
        end
        S_WAIT_ACK: begin
          r_wd <= w_wd_inc;
          // Ack wins over a timeout landing in the same cycle.
          if (mem.mem_ack) begin
            r_rdata <= w_cap_data;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0000_0000;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_wd    <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_wd    <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
